// File: rtl/bullet_engine.sv
// Bullet pool for the player sprite: spawns, moves and despawns up to NUM_BULLETS
// slots once per frame, and answers per-pixel "is there a bullet here" queries.
module bullet_engine #(
  parameter int         NUM_BULLETS = 4,
  parameter logic [9:0] SPEED       = 10'd4,
  parameter logic [3:0] COOLDOWN    = 4'd8,
  parameter logic [9:0] B_SIZE      = 10'd4
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   frame_clk,
  input  logic [7:0]             keycode,
  input  logic [9:0]             Player_X,
  input  logic [9:0]             Player_Y,
  input  logic [1:0]             Player_Direction,
  input  logic [9:0]             PixelX,
  input  logic [9:0]             PixelY,
  output logic                   is_bullet,
  output logic [3:0]             Bullet_address,
  output logic [NUM_BULLETS-1:0] Active_mask,
  output logic                   Fire_pulse
);

  logic                   frame_p0, frame_p1, frame_tick;
  logic [NUM_BULLETS-1:0] active;
  logic [9:0]             pos_x [NUM_BULLETS];
  logic [9:0]             pos_y [NUM_BULLETS];
  logic [1:0]             dir   [NUM_BULLETS];
  logic [3:0]             cooldown;
  logic [NUM_BULLETS-1:0] spawn_sel;
  logic                   found_free, spawn;
  logic                   hit_any;
  logic [3:0]             hit_addr;
  logic [9:0]             dist_x, dist_y;

  function automatic logic [3:0] sat_dec(input logic [3:0] v);
    return (v == 4'd0) ? 4'd0 : v - 4'd1;
  endfunction

  // Far-edge sums are widened to 11 bits so a bullet near 1023 never wraps back on screen.
  function automatic logic leaves_screen(input logic [1:0] d, input logic [9:0] x,
                                         input logic [9:0] y);
    logic [10:0] x_far;
    logic [10:0] y_far;
    x_far = {1'b0, x} + {1'b0, SPEED} + {1'b0, B_SIZE};
    y_far = {1'b0, y} + {1'b0, SPEED} + {1'b0, B_SIZE};
    case (d)
      2'd0:    leaves_screen = (y < SPEED);
      2'd1:    leaves_screen = (y_far > 11'd480);
      2'd2:    leaves_screen = (x < SPEED);
      default: leaves_screen = (x_far > 11'd640);
    endcase
  endfunction

  assign frame_tick  = frame_p0 & ~frame_p1;
  assign Active_mask = active;

  // Lowest free slot, judged on the pre-tick active bits so a slot despawning now stays busy.
  always_comb begin
    spawn_sel  = '0;
    found_free = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (!active[i] && !found_free) begin
        spawn_sel[i] = 1'b1;
        found_free   = 1'b1;
      end
    end
    spawn = frame_tick && (keycode == 8'd44) && (cooldown == 4'd0) && found_free;
  end

  // Descending scan so the lowest-index hitting slot is the one that sticks.
  always_comb begin
    hit_any  = 1'b0;
    hit_addr = 4'd0;
    dist_x   = '0;
    dist_y   = '0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (active[i] && (PixelX >= pos_x[i]) && (PixelY >= pos_y[i]) &&
          ({1'b0, PixelX} < {1'b0, pos_x[i]} + {1'b0, B_SIZE}) &&
          ({1'b0, PixelY} < {1'b0, pos_y[i]} + {1'b0, B_SIZE})) begin
        dist_x   = PixelX - pos_x[i];
        dist_y   = PixelY - pos_y[i];
        hit_any  = 1'b1;
        hit_addr = 4'(dist_y * B_SIZE + dist_x);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_p0       <= 1'b0;
      frame_p1       <= 1'b0;
      cooldown       <= 4'd0;
      Fire_pulse     <= 1'b0;
      is_bullet      <= 1'b0;
      Bullet_address <= 4'd0;
      active         <= '0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        pos_x[i] <= '0;
        pos_y[i] <= '0;
        dir[i]   <= 2'd0;
      end
    end else begin
      // stage p0/p1: frame_clk sampling and rising-edge history
      frame_p0       <= frame_clk;
      frame_p1       <= frame_p0;
      Fire_pulse     <= spawn;
      is_bullet      <= hit_any;
      Bullet_address <= hit_addr;
      if (frame_tick) begin
        cooldown <= spawn ? COOLDOWN : sat_dec(cooldown);
        for (int i = 0; i < NUM_BULLETS; i++) begin
          if (active[i]) begin
            if (leaves_screen(dir[i], pos_x[i], pos_y[i])) begin
              active[i] <= 1'b0;
            end else begin
              case (dir[i])
                2'd0:    pos_y[i] <= pos_y[i] - SPEED;
                2'd1:    pos_y[i] <= pos_y[i] + SPEED;
                2'd2:    pos_x[i] <= pos_x[i] - SPEED;
                default: pos_x[i] <= pos_x[i] + SPEED;
              endcase
            end
          end else if (spawn && spawn_sel[i]) begin
            active[i] <= 1'b1;
            pos_x[i]  <= Player_X + 10'd14;
            pos_y[i]  <= Player_Y + 10'd22;
            dir[i]    <= Player_Direction;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bullet_engine.sv
// Directed and randomized checks of bullet_engine against a slot-list reference model.
module tb_bullet_engine;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic [7:0] keycode;
  logic [9:0] Player_X, Player_Y;
  logic [1:0] Player_Direction;
  logic [9:0] PixelX, PixelY;
  logic       is_bullet;
  logic [3:0] Bullet_address;
  logic [3:0] Active_mask;
  logic       Fire_pulse;

  int n_cmp = 0;
  int n_bad = 0;
  bit dut_fire;

  int m_act [4];
  int m_x   [4];
  int m_y   [4];
  int m_dir [4];
  int m_cd;

  bullet_engine dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
    .Player_X(Player_X), .Player_Y(Player_Y), .Player_Direction(Player_Direction),
    .PixelX(PixelX), .PixelY(PixelY), .is_bullet(is_bullet),
    .Bullet_address(Bullet_address), .Active_mask(Active_mask), .Fire_pulse(Fire_pulse)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) begin
      m_act[k] = 0; m_x[k] = 0; m_y[k] = 0; m_dir[k] = 0;
    end
    m_cd = 0;
  endfunction

  // One frame of game rules: move or retire live bullets, then maybe fire into the first free slot.
  function automatic bit model_tick();
    int free_k = -1;
    bit fire;
    for (int k = 0; k < 4; k++) begin
      if (m_act[k] != 0) begin
        case (m_dir[k])
          0: if (m_y[k] < 4) m_act[k] = 0; else m_y[k] -= 4;
          1: if (m_y[k] + 8 > 480) m_act[k] = 0; else m_y[k] += 4;
          2: if (m_x[k] < 4) m_act[k] = 0; else m_x[k] -= 4;
          default: if (m_x[k] + 8 > 640) m_act[k] = 0; else m_x[k] += 4;
        endcase
      end else if (free_k < 0) begin
        free_k = k;
      end
    end
    fire = (keycode == 8'd44) && (m_cd == 0) && (free_k >= 0);
    if (fire) begin
      m_act[free_k] = 1;
      m_x[free_k]   = (int'(Player_X) + 14) % 1024;
      m_y[free_k]   = (int'(Player_Y) + 22) % 1024;
      m_dir[free_k] = int'(Player_Direction);
      m_cd = 8;
    end else if (m_cd > 0) begin
      m_cd--;
    end
    return fire;
  endfunction

  function automatic int model_mask();
    int r = 0;
    for (int k = 0; k < 4; k++) if (m_act[k] != 0) r |= (1 << k);
    return r;
  endfunction

  function automatic int model_hit(input int px, input int py);
    for (int k = 0; k < 4; k++)
      if (m_act[k] != 0 && px >= m_x[k] && px < m_x[k] + 4 && py >= m_y[k] && py < m_y[k] + 4)
        return (py - m_y[k]) * 4 + (px - m_x[k]);
    return -1;
  endfunction

  task automatic do_tick(input string tag);
    bit fire;
    frame_clk = 1'b1;
    step();
    step();
    fire     = model_tick();
    dut_fire = Fire_pulse;
    check({tag, "_fire"}, Fire_pulse, fire);
    check({tag, "_mask"}, Active_mask, model_mask());
    frame_clk = 1'b0;
    step();
    check({tag, "_fire_end"}, Fire_pulse, 0);
  endtask

  task automatic probe(input string tag, input int px, input int py);
    int e;
    PixelX = 10'(px & 1023);
    PixelY = 10'(py & 1023);
    step();
    e = model_hit(px & 1023, py & 1023);
    check({tag, "_hit"}, is_bullet, e >= 0);
    check({tag, "_addr"}, Bullet_address, (e >= 0) ? e : 0);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic set_player(input int x, input int y, input int d);
    Player_X = 10'(x);
    Player_Y = 10'(y);
    Player_Direction = 2'(d);
  endtask

  initial begin
    Reset = 1'b1; frame_clk = 1'b0; keycode = 8'd0;
    set_player(0, 0, 0);
    PixelX = 10'd0; PixelY = 10'd0;
    model_reset();
    repeat (3) step();
    check("rst_mask", Active_mask, 0);
    check("rst_fire", Fire_pulse, 0);
    check("rst_hit", is_bullet, 0);
    check("rst_addr", Bullet_address, 0);
    Reset = 1'b0;
    step();

    // single shot to the right, then one move
    set_player(100, 200, 3);
    keycode = 8'd44;
    do_tick("shot1");
    check("shot1_spawned", dut_fire, 1);
    check("shot1_mask1", Active_mask, 4'b0001);
    probe("shot1_origin", 114, 222);
    keycode = 8'd0;
    do_tick("shot1_move");
    check("shot1_mask2", Active_mask, 4'b0001);
    probe("shot1_moved", 119, 224);
    probe("shot1_old", 114, 222);

    // bullet parked at (300,100) for pixel hit tests
    do_reset();
    set_player(286, 78, 0);
    keycode = 8'd44;
    do_tick("park");
    keycode = 8'd0;
    probe("px302_101", 302, 101);
    check("px302_101_addr6", Bullet_address, 6);
    probe("px304_101", 304, 101);
    check("px304_101_miss", is_bullet, 0);
    probe("px303_103", 303, 103);
    probe("px299_100", 299, 100);
    probe("px300_104", 300, 104);

    // upward bullet at Y=5 retires at the top edge without wrapping
    do_reset();
    set_player(50, 1007, 0);
    keycode = 8'd44;
    do_tick("top_spawn");
    keycode = 8'd0;
    do_tick("top_y1");
    probe("top_y1_px", 64, 1);
    check("top_y1_addr", Bullet_address, 0);
    do_tick("top_gone");
    check("top_gone_mask", Active_mask, 0);
    probe("top_gone_px", 64, 1);
    probe("top_nowrap", 64, 1021);

    // space held: four spawns, blocked while full, refire one tick after slot 0 retires
    do_reset();
    keycode = 8'd44;
    for (int t = 0; t <= 53; t++) begin
      if (t == 0) set_player(0, 178, 0);
      else        set_player(0, 0, 3);
      do_tick($sformatf("hold_t%0d", t));
      check($sformatf("hold_spawn_t%0d", t), dut_fire,
            (t == 0 || t == 9 || t == 18 || t == 27 || t == 52));
      if (t == 27 || t == 52) check($sformatf("hold_full_t%0d", t), Active_mask, 4'b1111);
      if (t == 51) check("hold_freed_t51", Active_mask, 4'b1110);
    end

    // reset mid-flight drops every bullet and clears the cooldown
    probe("pre_rst", m_x[1] + 1, m_y[1] + 1);
    check("pre_rst_hit", is_bullet, 1);
    Reset = 1'b1;
    step();
    check("midrst_mask", Active_mask, 0);
    check("midrst_hit", is_bullet, 0);
    Reset = 1'b0;
    model_reset();
    do_tick("post_rst");
    check("post_rst_fire", dut_fire, 1);

    // randomized frames with pixel probes around live bullets
    do_reset();
    for (int t = 0; t < 250; t++) begin
      keycode = ($urandom_range(0, 9) < 7) ? 8'd44 : 8'($urandom_range(0, 255));
      set_player(int'($urandom_range(0, 640)), int'($urandom_range(0, 470)),
                 int'($urandom_range(0, 3)));
      do_tick($sformatf("rnd_t%0d", t));
      for (int p = 0; p < 2; p++) begin
        int k = int'($urandom_range(0, 3));
        if (m_act[k] != 0)
          probe($sformatf("rnd_probe_t%0d_%0d", t, p),
                m_x[k] + int'($urandom_range(0, 5)) - 1, m_y[k] + int'($urandom_range(0, 5)) - 1);
        else
          probe($sformatf("rnd_probe_t%0d_%0d", t, p),
                int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
